// File: rtl/mk14_key_scheduler_if.sv
// mk14_key_scheduler_if
// ---------------------
// Key-event request bundle shared by the two requesters of the MK14 key
// scheduler: requester A (e.g. the IR decoder) and requester B (e.g. the
// TM1638 front-panel scanner). Each requester offers a matrix coordinate
// {addr, bit} with a valid/ready handshake. An event transfers in any cycle
// where valid and ready are both high.
//
// Signals:
//   a_valid / b_valid  requester has an event (driven by requester)
//   a_ready / b_ready  scheduler accepts the event (driven by scheduler)
//   a_addr  / b_addr   3-bit keyboard-matrix row address
//   a_bit   / b_bit    3-bit keyboard-matrix bit within the row
//
// Modports:
//   master  requester side (drives valid/addr/bit, samples ready)
//   slave   scheduler side (samples valid/addr/bit, drives ready)

interface mk14_key_scheduler_if;

    logic       a_valid;
    logic       a_ready;
    logic [2:0] a_addr;
    logic [2:0] a_bit;

    logic       b_valid;
    logic       b_ready;
    logic [2:0] b_addr;
    logic [2:0] b_bit;

    modport master (
        output a_valid, a_addr, a_bit,
        output b_valid, b_addr, b_bit,
        input  a_ready, b_ready
    );

    modport slave (
        input  a_valid, a_addr, a_bit,
        input  b_valid, b_addr, b_bit,
        output a_ready, b_ready
    );

endinterface

// File: rtl/mk14_key_scheduler.sv
// mk14_key_scheduler
// ------------------
// Turns key events from two requesters into timed press/release writes on
// the MMU keyboard-matrix port. Requests are arbitrated round-robin, queued
// in a small FIFO and then replayed one at a time as
//   press strobe -> HOLD_CYCLES -> release strobe -> GAP_CYCLES -> next press
// so that every key is eventually released and consecutive keys are
// separated by a quiet gap the monitor ROM can see.
//
// Parameters:
//   HOLD_CYCLES  cycles from press strobe to release strobe (>= 1)
//   GAP_CYCLES   minimum cycles after a release strobe before the next
//                press, the press itself landing GAP_CYCLES+1 after (>= 1)
//   FIFO_DEPTH   queued events, power of two (>= 2)
//
// Ports:
//   clk           clock
//   rst_n         synchronous active-low reset
//   req           requester bundle (slave side): a_* and b_* handshakes
//   flush         level abort: drops the queue, forces release of a held key
//   kbd_write_en  one-cycle matrix write strobe
//   kbd_addr      matrix row for the strobe (holds between strobes)
//   kbd_bit       matrix bit for the strobe (holds between strobes)
//   kbd_pressed   1 = press, 0 = release; reflects the last strobe type
//   busy          sequencer active or FIFO holding events
//   fifo_count    queued entries, not counting the event being replayed

module mk14_key_scheduler #(
    parameter int HOLD_CYCLES = 2500000,
    parameter int GAP_CYCLES  = 1000000,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    mk14_key_scheduler_if.slave         req,
    input  logic                        flush,
    output logic                        kbd_write_en,
    output logic [2:0]                  kbd_addr,
    output logic [2:0]                  kbd_bit,
    output logic                        kbd_pressed,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

    localparam int PTR_W      = $clog2(FIFO_DEPTH);
    localparam int CNT_W      = PTR_W + 1;
    localparam int MAX_CYCLES = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int TIMER_W    = $clog2(MAX_CYCLES + 1);

    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(FIFO_DEPTH);

    // The timer counts down to zero and the exit decision is taken in the
    // cycle it reads zero, so the loads are trimmed to land the next strobe
    // on the exact cycle. HOLD loses one more because the PRESS cycle itself
    // counts towards the hold time.
    localparam logic [TIMER_W-1:0] HOLD_LOAD =
        (HOLD_CYCLES >= 2) ? TIMER_W'(HOLD_CYCLES - 2) : TIMER_W'(0);
    localparam logic [TIMER_W-1:0] GAP_LOAD = TIMER_W'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        PRESS,
        HOLD,
        RELEASE,
        GAP
    } state_t;

    state_t             state;
    logic [TIMER_W-1:0] timer;

    logic [5:0]         fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;

    // 0: requester A has priority on a tie, 1: requester B does.
    logic               prio_b;

    logic               full;
    logic               empty;
    logic               a_grant;
    logic               b_grant;
    logic               enq;
    logic               pop;
    logic [5:0]         enq_data;
    logic [5:0]         head;

    assign full  = (count == FULL_COUNT);
    assign empty = (count == '0);

    // Round-robin arbitration. A lone requester always wins; on a tie the
    // one named by prio_b wins. Nothing is accepted while flush is high so
    // the flushed queue really ends up empty.
    assign req.a_ready = !full && !flush && req.a_valid && (!req.b_valid || !prio_b);
    assign req.b_ready = !full && !flush && req.b_valid && (!req.a_valid ||  prio_b);

    assign a_grant  = req.a_valid && req.a_ready;
    assign b_grant  = req.b_valid && req.b_ready;
    assign enq      = a_grant || b_grant;
    assign enq_data = a_grant ? {req.a_addr, req.a_bit} : {req.b_addr, req.b_bit};
    assign head     = fifo_mem[rd_ptr];

    // The sequencer takes the head of the queue either from IDLE or at the
    // last GAP cycle, which is what makes back-to-back keys land exactly
    // GAP_CYCLES+1 after the previous release.
    assign pop = !flush && !empty &&
                 ((state == IDLE) || ((state == GAP) && (timer == '0)));

    assign busy       = (state != IDLE) || !empty;
    assign fifo_count = count;

    // Priority flips to the other requester only when someone is granted,
    // so an idle requester does not lose its turn while nobody asks.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prio_b <= 1'b0;
        end else if (a_grant) begin
            prio_b <= 1'b1;
        end else if (b_grant) begin
            prio_b <= 1'b0;
        end
    end

    // FIFO storage. No reset is needed here: the pointers and count below
    // decide which entries are meaningful.
    always_ff @(posedge clk) begin
        if (enq) begin
            fifo_mem[wr_ptr] <= enq_data;
        end
    end

    // FIFO pointers and occupancy. Pointers wrap naturally because the depth
    // is a power of two. A push and a pop in the same cycle leave the count
    // unchanged. Flush discards everything at once.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (enq) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({enq, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Press/hold/release/gap sequencer. The strobe is registered together
    // with the state change, so the cycle spent in PRESS or RELEASE is the
    // cycle the strobe is visible on the matrix port. kbd_addr/kbd_bit double
    // as the in-flight event register: they are loaded on the press and left
    // alone on the release, so the release always names the same key.
    // A flush while the key is down cuts the hold short; once the release has
    // been issued the sequence simply runs out with an empty queue.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            timer        <= '0;
            kbd_write_en <= 1'b0;
            kbd_addr     <= '0;
            kbd_bit      <= '0;
            kbd_pressed  <= 1'b0;
        end else begin
            kbd_write_en <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (pop) begin
                        kbd_write_en <= 1'b1;
                        kbd_pressed  <= 1'b1;
                        kbd_addr     <= head[5:3];
                        kbd_bit      <= head[2:0];
                        state        <= PRESS;
                    end
                end
                PRESS: begin
                    if (flush || (HOLD_CYCLES == 1)) begin
                        kbd_write_en <= 1'b1;
                        kbd_pressed  <= 1'b0;
                        state        <= RELEASE;
                    end else begin
                        timer <= HOLD_LOAD;
                        state <= HOLD;
                    end
                end
                HOLD: begin
                    if (flush || (timer == '0)) begin
                        kbd_write_en <= 1'b1;
                        kbd_pressed  <= 1'b0;
                        state        <= RELEASE;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                RELEASE: begin
                    timer <= GAP_LOAD;
                    state <= GAP;
                end
                GAP: begin
                    if (timer == '0) begin
                        if (pop) begin
                            kbd_write_en <= 1'b1;
                            kbd_pressed  <= 1'b1;
                            kbd_addr     <= head[5:3];
                            kbd_bit      <= head[2:0];
                            state        <= PRESS;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Structural invariants: the queue never overfills, only one requester
    // is granted per cycle, and strobes only come from the strobe states.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (count <= FULL_COUNT);
            assert (!(a_grant && b_grant));
            assert (!kbd_write_en || (state == PRESS) || (state == RELEASE));
        end
    end

endmodule

// File: tb/tb_mk14_key_scheduler.sv
// tb_mk14_key_scheduler
// ---------------------
// Bench for mk14_key_scheduler with HOLD_CYCLES=4, GAP_CYCLES=3,
// FIFO_DEPTH=4. A cycle-level behavioural model (queue of codes plus
// scheduled press/release times) predicts every output each cycle; directed
// scenarios add hand-computed literal expectations on strobe timing, order
// and arbitration.
//
// Ports of the bench: none (top level).

module tb_mk14_key_scheduler;

    localparam int H = 4;
    localparam int G = 3;
    localparam int DEPTH = 4;
    localparam int ACCEPT_BUDGET = 60;

    logic       clk;
    logic       rst_n;
    logic       flush;
    logic       kbd_write_en;
    logic [2:0] kbd_addr;
    logic [2:0] kbd_bit;
    logic       kbd_pressed;
    logic       busy;
    logic [$clog2(DEPTH):0] fifo_count;

    mk14_key_scheduler_if bus ();

    mk14_key_scheduler #(
        .HOLD_CYCLES (H),
        .GAP_CYCLES  (G),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req          (bus),
        .flush        (flush),
        .kbd_write_en (kbd_write_en),
        .kbd_addr     (kbd_addr),
        .kbd_bit      (kbd_bit),
        .kbd_pressed  (kbd_pressed),
        .busy         (busy),
        .fifo_count   (fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int compared = 0;
    int mismatched = 0;

    typedef struct {
        int         cyc;
        logic [2:0] addr;
        logic [2:0] bt;
        logic       pressed;
    } strobe_t;

    strobe_t strobes[$];

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)",
                     name, actual, expected, cyc);
        end
    endtask

    task automatic report_timeout(input string name);
        compared++;
        mismatched++;
        $display("[TB] FAIL %s: timed out, got no event, expected one (cycle %0d)", name, cyc);
    endtask

    // ---------------- behavioural model ----------------
    logic [5:0] mq[$];
    bit         m_valid = 0;
    bit         m_prio_b;
    bit         m_inflight;
    logic [5:0] m_key;
    int         m_press;
    int         m_release;
    int         m_last_release;
    int         m_next_ok;
    bit         e_we;
    bit         e_pressed;
    logic [2:0] e_addr;
    logic [2:0] e_bit;
    int         e_count;
    bit         e_busy;
    bit         e_ar;
    bit         e_br;
    strobe_t    s_tmp;

    task automatic model_reset();
        mq.delete();
        m_prio_b       = 0;
        m_inflight     = 0;
        m_key          = '0;
        m_press        = -1000;
        m_release      = -1000;
        m_last_release = -1000;
        m_next_ok      = 0;
        e_we = 0; e_pressed = 0; e_addr = '0; e_bit = '0;
        e_count = 0; e_busy = 0;
    endtask

    // Advance the model from cycle c to c+1 using the inputs seen in cycle c.
    task automatic model_step(input int c);
        if (m_inflight && flush && c >= m_press && c < m_release)
            m_release = c + 1;
        if (!m_inflight && !flush && mq.size() > 0 && c + 1 >= m_next_ok) begin
            m_key      = mq.pop_front();
            m_inflight = 1;
            m_press    = c + 1;
            m_release  = c + 1 + H;
        end
        if (flush) mq.delete();
        if (e_ar) begin
            mq.push_back({bus.a_addr, bus.a_bit});
            m_prio_b = 1;
        end else if (e_br) begin
            mq.push_back({bus.b_addr, bus.b_bit});
            m_prio_b = 0;
        end
        e_we = 0;
        if (m_inflight && m_press == c + 1) begin
            e_we = 1; e_pressed = 1; e_addr = m_key[5:3]; e_bit = m_key[2:0];
        end else if (m_inflight && m_release == c + 1) begin
            e_we = 1; e_pressed = 0;
            m_inflight     = 0;
            m_last_release = c + 1;
            m_next_ok      = c + 1 + G + 1;
        end
        e_count = mq.size();
        e_busy  = (mq.size() != 0) || m_inflight || (c + 1 <= m_last_release + G);
    endtask

    // Compare process: every cycle once reset has been seen.
    always @(negedge clk) begin
        if (m_valid) begin
            check_output("kbd_write_en", kbd_write_en, e_we);
            check_output("kbd_addr", kbd_addr, e_addr);
            check_output("kbd_bit", kbd_bit, e_bit);
            check_output("kbd_pressed", kbd_pressed, e_pressed);
            check_output("busy", busy, e_busy);
            check_output("fifo_count", fifo_count, e_count);
            if (kbd_write_en === 1'b1) begin
                s_tmp.cyc = cyc; s_tmp.addr = kbd_addr;
                s_tmp.bt = kbd_bit; s_tmp.pressed = kbd_pressed;
                strobes.push_back(s_tmp);
            end
        end
        if (rst_n !== 1'b1) begin
            model_reset();
            m_valid = 1;
        end else if (m_valid) begin
            e_ar = (mq.size() != DEPTH) && !flush && bus.a_valid && (!bus.b_valid || !m_prio_b);
            e_br = (mq.size() != DEPTH) && !flush && bus.b_valid && (!bus.a_valid ||  m_prio_b);
            check_output("a_ready", bus.a_ready, e_ar);
            check_output("b_ready", bus.b_ready, e_br);
            model_step(cyc);
        end
    end

    // ---------------- stimulus helpers ----------------
    // All helpers start and end 2 time units after a rising edge.
    task automatic reset_dut(input int n);
        rst_n = 0;
        repeat (n) begin
            @(posedge clk);
            #2;
        end
        rst_n = 1;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic apply_stimulus(input bit use_b, input logic [5:0] code, output int acc);
        int waited;
        bit got;
        waited = 0;
        got    = 0;
        acc    = -1;
        if (use_b) begin
            bus.b_valid = 1; bus.b_addr = code[5:3]; bus.b_bit = code[2:0];
        end else begin
            bus.a_valid = 1; bus.a_addr = code[5:3]; bus.a_bit = code[2:0];
        end
        while (!got && waited < ACCEPT_BUDGET) begin
            @(negedge clk);
            if ((use_b ? bus.b_ready : bus.a_ready) === 1'b1) begin
                got = 1;
                acc = cyc;
            end
            waited++;
        end
        if (!got) report_timeout(use_b ? "b_accept" : "a_accept");
        @(posedge clk);
        #2;
        if (use_b) bus.b_valid = 0;
        else       bus.a_valid = 0;
    endtask

    task automatic wait_idle(input int budget, output int idle_cyc);
        int waited;
        bit done;
        waited   = 0;
        done     = 0;
        idle_cyc = -1;
        while (!done && waited < budget) begin
            @(negedge clk);
            if (busy === 1'b0) begin
                done     = 1;
                idle_cyc = cyc;
            end
            waited++;
        end
        if (!done) report_timeout("busy_fall");
        @(posedge clk);
        #2;
    endtask

    task automatic check_strobe(input string name, input int idx, input int exp_cyc,
                                input logic [5:0] code, input bit pressed);
        check_output({name, "_cyc"}, strobes[idx].cyc, exp_cyc);
        check_output({name, "_addr"}, strobes[idx].addr, code[5:3]);
        check_output({name, "_bit"}, strobes[idx].bt, code[2:0]);
        check_output({name, "_pressed"}, strobes[idx].pressed, pressed);
    endtask

    // ---------------- directed scenarios ----------------
    logic [5:0] t3_codes [6] = '{6'o10, 6'o11, 6'o12, 6'o13, 6'o14, 6'o15};
    logic [5:0] t4_codes [3] = '{6'o01, 6'o02, 6'o03};
    logic [5:0] t6_a [4]     = '{6'o20, 6'o21, 6'o22, 6'o23};
    logic [5:0] t6_b [4]     = '{6'o30, 6'o31, 6'o32, 6'o33};
    int         t6_a_off [4] = '{0, 2, 4, 18};
    int         t6_b_off [4] = '{1, 3, 10, 26};
    int         acc_a [4];
    int         acc_b [4];
    int         acc3 [6];

    initial begin
        int ta;
        int tb_acc;
        int idle_c;
        int dummy;
        logic [5:0] c6;

        rst_n = 0;
        flush = 0;
        bus.a_valid = 0; bus.a_addr = '0; bus.a_bit = '0;
        bus.b_valid = 0; bus.b_addr = '0; bus.b_bit = '0;
        reset_dut(2);

        // 1: single key {3,5} from A into an idle scheduler.
        @(negedge clk);
        check_output("t1_reset_busy", busy, 0);
        check_output("t1_reset_count", fifo_count, 0);
        @(posedge clk); #2;
        strobes.delete();
        apply_stimulus(0, 6'o35, ta);
        wait_idle(40, idle_c);
        check_output("t1_strobes", strobes.size(), 2);
        check_strobe("t1_press", 0, ta + 2, 6'o35, 1);
        check_strobe("t1_release", 1, ta + 6, 6'o35, 0);
        check_output("t1_idle_cyc", idle_c, ta + 10);

        // 2: simultaneous A {0,7} and B {1,7}, priority on A.
        reset_dut(1);
        strobes.delete();
        bus.a_valid = 1; bus.a_addr = 3'd0; bus.a_bit = 3'd7;
        bus.b_valid = 1; bus.b_addr = 3'd1; bus.b_bit = 3'd7;
        @(negedge clk);
        ta = cyc;
        check_output("t2_a_ready", bus.a_ready, 1);
        check_output("t2_b_wait", bus.b_ready, 0);
        @(posedge clk); #2;
        bus.a_valid = 0;
        @(negedge clk);
        check_output("t2_b_ready", bus.b_ready, 1);
        @(posedge clk); #2;
        bus.b_valid = 0;
        wait_idle(60, idle_c);
        check_output("t2_strobes", strobes.size(), 4);
        check_strobe("t2_a_press", 0, ta + 2, 6'o07, 1);
        check_strobe("t2_a_release", 1, ta + 6, 6'o07, 0);
        check_strobe("t2_b_press", 2, ta + 10, 6'o17, 1);
        check_strobe("t2_b_release", 3, ta + 14, 6'o17, 0);

        // 3: B streams six codes; queue fills behind the in-flight key.
        reset_dut(1);
        strobes.delete();
        for (int i = 0; i < 5; i++) apply_stimulus(1, t3_codes[i], acc3[i]);
        c6 = t3_codes[5];
        bus.b_valid = 1; bus.b_addr = c6[5:3]; bus.b_bit = c6[2:0];
        @(negedge clk);
        check_output("t3_full_count", fifo_count, 4);
        check_output("t3_full_ready", bus.b_ready, 0);
        apply_stimulus(1, c6, acc3[5]);
        check_output("t3_sixth_accept", acc3[5], acc3[0] + 10);
        wait_idle(120, idle_c);
        check_output("t3_strobes", strobes.size(), 12);
        for (int i = 0; i < 6; i++) begin
            check_output("t3_press_code", {strobes[2*i].addr, strobes[2*i].bt}, t3_codes[i]);
            check_output("t3_press_flag", strobes[2*i].pressed, 1);
            check_output("t3_rel_code", {strobes[2*i+1].addr, strobes[2*i+1].bt}, t3_codes[i]);
            check_output("t3_rel_flag", strobes[2*i+1].pressed, 0);
        end

        // 4: flush during HOLD of {2,5} with three entries queued.
        reset_dut(1);
        strobes.delete();
        apply_stimulus(0, 6'o25, ta);
        for (int i = 0; i < 3; i++) apply_stimulus(1, t4_codes[i], dummy);
        flush = 1;
        bus.a_valid = 1; bus.a_addr = 3'd7; bus.a_bit = 3'd7;
        @(negedge clk);
        check_output("t4_queued", fifo_count, 3);
        check_output("t4_flush_a_ready", bus.a_ready, 0);
        @(posedge clk); #2;
        flush = 0;
        bus.a_valid = 0;
        @(negedge clk);
        check_output("t4_count_after", fifo_count, 0);
        check_output("t4_release_now", kbd_write_en, 1);
        @(posedge clk); #2;
        wait_idle(40, idle_c);
        check_output("t4_strobes", strobes.size(), 2);
        check_strobe("t4_press", 0, ta + 2, 6'o25, 1);
        check_strobe("t4_release", 1, ta + 5, 6'o25, 0);

        // 5: one-cycle reset during HOLD, then A/B tie must go to A.
        reset_dut(1);
        strobes.delete();
        apply_stimulus(0, 6'o42, ta);
        idle_cycles(2);
        reset_dut(1);
        @(negedge clk);
        check_output("t5_we", kbd_write_en, 0);
        check_output("t5_addr", kbd_addr, 0);
        check_output("t5_bit", kbd_bit, 0);
        check_output("t5_pressed", kbd_pressed, 0);
        check_output("t5_busy", busy, 0);
        check_output("t5_count", fifo_count, 0);
        @(posedge clk); #2;
        idle_cycles(6);
        check_output("t5_no_release", strobes.size(), 1);
        bus.a_valid = 1; bus.a_addr = 3'd5; bus.a_bit = 3'd1;
        bus.b_valid = 1; bus.b_addr = 3'd6; bus.b_bit = 3'd0;
        @(negedge clk);
        tb_acc = cyc;
        check_output("t5_prio_a", bus.a_ready, 1);
        check_output("t5_prio_b_wait", bus.b_ready, 0);
        @(posedge clk); #2;
        bus.a_valid = 0;
        apply_stimulus(1, 6'o60, dummy);
        wait_idle(60, idle_c);
        check_output("t5_strobes", strobes.size(), 5);
        check_strobe("t5_new_press", 1, tb_acc + 2, 6'o51, 1);

        // 6: both requesters continuously valid through a full FIFO.
        reset_dut(1);
        strobes.delete();
        fork
            for (int i = 0; i < 4; i++) apply_stimulus(0, t6_a[i], acc_a[i]);
            for (int j = 0; j < 4; j++) apply_stimulus(1, t6_b[j], acc_b[j]);
        join
        wait_idle(120, idle_c);
        for (int i = 0; i < 4; i++) begin
            check_output("t6_a_grant", acc_a[i], acc_a[0] + t6_a_off[i]);
            check_output("t6_b_grant", acc_b[i], acc_a[0] + t6_b_off[i]);
        end
        check_output("t6_strobes", strobes.size(), 16);
        for (int i = 0; i < 4; i++) begin
            check_output("t6_press_a", {strobes[4*i].addr, strobes[4*i].bt}, t6_a[i]);
            check_output("t6_press_b", {strobes[4*i+2].addr, strobes[4*i+2].bt}, t6_b[i]);
        end

        idle_cycles(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
